// File: rtl/vector_output_drain.sv
// vector_output_drain
// Captures packed CPU output vectors into a small vector FIFO and drains
// each buffered vector as a stream of OUTPUT_WIDTH-bit elements over a
// valid/ready interface, element 0 (least-significant slice) first.
// The vector being streamed stays at the FIFO head until its last element
// transfers. Occupancy therefore counts it, and it is popped on that final
// transfer. VECTOR_SIZE must be at least 2 and FIFO_DEPTH a power of two >= 2.

module vector_output_drain #(
    parameter int VECTOR_SIZE  = 8,
    parameter int OUTPUT_WIDTH = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] out,
    input  logic                                outFlag,
    output logic [OUTPUT_WIDTH-1:0]             elem_data,
    output logic                                elem_valid,
    input  logic                                elem_ready,
    output logic                                elem_last,
    output logic                                overflow,
    output logic [COUNT_WIDTH-1:0]              vec_count,
    output logic                                busy
);

    localparam int VEC_W = VECTOR_SIZE * OUTPUT_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Vector storage and FIFO bookkeeping
    logic [VEC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [OCC_W-1:0] occ_reg;

    // Streaming side
    state_t            state_reg;
    logic [VEC_W-1:0]  shift_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              elem_valid_reg;
    logic              elem_last_reg;
    logic              overflow_reg;
    logic [COUNT_WIDTH-1:0] vec_count_reg;

    // Per-edge events
    logic             xfer;
    logic             pop;
    logic             push;
    logic             drop;
    logic             more_after_pop;
    logic [PTR_W-1:0] head_next_ptr;
    logic [VEC_W-1:0] follow_vec;

    assign xfer = (state_reg == SEND) && elem_valid_reg && elem_ready;
    assign pop  = xfer && (idx_reg == LAST_IDX);

    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push = outFlag && ((occ_reg != OCC_FULL) || pop);
    assign drop = outFlag && !push;

    // After popping the head, another vector is present if one was already
    // queued behind it, or if one is being pushed on this very edge.
    assign more_after_pop = (occ_reg > OCC_W'(1)) || push;
    assign head_next_ptr  = head_reg + PTR_W'(1);

    // The vector following the head comes from storage when it was queued
    // earlier; with only the head stored it can only be the incoming push.
    assign follow_vec = (occ_reg > OCC_W'(1)) ? mem[head_next_ptr] : out;

    // Vector storage write port; contents need no reset since the pointers gate use
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail_reg] <= out;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_next_ptr;
            end
            occ_reg <= occ_reg + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Accepted-vector counter and sticky overflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            vec_count_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (push) begin
                vec_count_reg <= vec_count_reg + COUNT_WIDTH'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Drain FSM: loads the head vector and shifts one element out per transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            idx_reg        <= '0;
            elem_valid_reg <= 1'b0;
            elem_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (occ_reg != '0) begin
                        shift_reg      <= mem[head_reg];
                        idx_reg        <= '0;
                        elem_valid_reg <= 1'b1;
                        elem_last_reg  <= 1'b0;
                        state_reg      <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (idx_reg != LAST_IDX) begin
                            shift_reg     <= shift_reg >> OUTPUT_WIDTH;
                            idx_reg       <= idx_reg + IDX_W'(1);
                            elem_last_reg <= ((idx_reg + IDX_W'(1)) == LAST_IDX);
                        end else if (more_after_pop) begin
                            shift_reg      <= follow_vec;
                            idx_reg        <= '0;
                            elem_valid_reg <= 1'b1;
                            elem_last_reg  <= 1'b0;
                        end else begin
                            idx_reg        <= '0;
                            elem_valid_reg <= 1'b0;
                            elem_last_reg  <= 1'b0;
                            state_reg      <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    elem_valid_reg <= 1'b0;
                    elem_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign elem_data  = shift_reg[OUTPUT_WIDTH-1:0];
    assign elem_valid = elem_valid_reg;
    assign elem_last  = elem_last_reg;
    assign overflow   = overflow_reg;
    assign vec_count  = vec_count_reg;
    assign busy       = (occ_reg != '0) || (state_reg != IDLE);

endmodule

// File: tb/tb_vector_output_drain.sv
// Directed testbench for vector_output_drain with default parameters
// (8 elements of 8 bits, 4-deep FIFO, 16-bit vector counter).

module tb_vector_output_drain;

    logic        clock;
    logic        reset;
    logic [63:0] out;
    logic        outFlag;
    logic [7:0]  elem_data;
    logic        elem_valid;
    logic        elem_ready;
    logic        elem_last;
    logic        overflow;
    logic [15:0] vec_count;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    vector_output_drain #(
        .VECTOR_SIZE (8),
        .OUTPUT_WIDTH(8),
        .FIFO_DEPTH  (4),
        .COUNT_WIDTH (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .out       (out),
        .outFlag   (outFlag),
        .elem_data (elem_data),
        .elem_valid(elem_valid),
        .elem_ready(elem_ready),
        .elem_last (elem_last),
        .overflow  (overflow),
        .vec_count (vec_count),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        outFlag    = 1'b0;
        elem_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Element j of test vector i: high nibble i+1, low nibble j.
    function automatic logic [7:0] elem_of(input int i, input int j);
        return 8'((i + 1) * 16 + j);
    endfunction

    function automatic logic [63:0] make_vec(input int i);
        logic [63:0] v;
        for (int j = 0; j < 8; j++) begin
            v[j*8 +: 8] = elem_of(i, j);
        end
        return v;
    endfunction

    initial begin
        int  exp_idx;
        bit  prev_hold;
        logic [7:0] prev_data;

        reset      = 1'b0;
        out        = '0;
        outFlag    = 1'b0;
        elem_ready = 1'b0;

        // ---------------- Reset then idle ----------------
        do_reset();
        check("rst_valid", 64'(elem_valid), 64'(0));
        check("rst_last", 64'(elem_last), 64'(0));
        check("rst_data", 64'(elem_data), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_cnt", 64'(vec_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        elem_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_valid", 64'(elem_valid), 64'(0));
            check("idle_busy", 64'(busy), 64'(0));
        end
        check("idle_cnt", 64'(vec_count), 64'(0));
        check("idle_ovf", 64'(overflow), 64'(0));

        // ---------------- Single vector, ready=1 ----------------
        do_reset();
        elem_ready = 1'b1;
        out        = 64'h0807060504030201;
        outFlag    = 1'b1;
        step();                       // edge k: capture
        outFlag = 1'b0;
        check("single_lat_valid", 64'(elem_valid), 64'(0));
        check("single_lat_busy", 64'(busy), 64'(1));
        check("single_cnt", 64'(vec_count), 64'(1));
        step();                       // edge k+1: load
        for (int i = 0; i < 8; i++) begin
            check("single_valid", 64'(elem_valid), 64'(1));
            check("single_data", 64'(elem_data), 64'(i + 1));
            check("single_last", 64'(elem_last), 64'(i == 7));
            step();
        end
        check("single_end_valid", 64'(elem_valid), 64'(0));
        check("single_end_busy", 64'(busy), 64'(0));
        check("single_end_cnt", 64'(vec_count), 64'(1));

        // ---------------- Backpressure ----------------
        do_reset();
        out     = 64'h0807060504030201;
        outFlag = 1'b1;
        step();
        outFlag   = 1'b0;
        exp_idx   = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 40; c++) begin
            elem_ready = (c % 3 == 0);
            if (prev_hold) begin
                check("bp_hold_valid", 64'(elem_valid), 64'(1));
                check("bp_hold_data", 64'(elem_data), 64'(prev_data));
            end
            if (elem_valid && elem_ready) begin
                check("bp_data", 64'(elem_data), 64'(exp_idx + 1));
                check("bp_last", 64'(elem_last), 64'(exp_idx == 7));
                exp_idx++;
            end
            prev_hold = elem_valid && !elem_ready;
            prev_data = elem_data;
            step();
        end
        check("bp_count", 64'(exp_idx), 64'(8));
        check("bp_end_valid", 64'(elem_valid), 64'(0));

        // ---------------- Overflow ----------------
        do_reset();
        elem_ready = 1'b0;
        outFlag    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            out = make_vec(i);
            step();
        end
        outFlag = 1'b0;
        check("ovf_cnt", 64'(vec_count), 64'(4));
        check("ovf_flag", 64'(overflow), 64'(1));
        check("ovf_busy", 64'(busy), 64'(1));
        elem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                check("ovf_drain_valid", 64'(elem_valid), 64'(1));
                check("ovf_drain_data", 64'(elem_data), 64'(elem_of(i, j)));
                check("ovf_drain_last", 64'(elem_last), 64'(j == 7));
                step();
            end
        end
        check("ovf_end_valid", 64'(elem_valid), 64'(0));
        check("ovf_end_cnt", 64'(vec_count), 64'(4));
        check("ovf_end_flag", 64'(overflow), 64'(1));

        // ---------------- Push while draining last element ----------------
        do_reset();
        elem_ready = 1'b0;
        outFlag    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out = make_vec(i);
            step();
        end
        outFlag    = 1'b0;
        elem_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            step();
        end
        check("pl_pre_data", 64'(elem_data), 64'(elem_of(0, 7)));
        check("pl_pre_last", 64'(elem_last), 64'(1));
        check("pl_pre_cnt", 64'(vec_count), 64'(4));
        out     = make_vec(4);
        outFlag = 1'b1;
        step();
        outFlag = 1'b0;
        check("pl_ovf", 64'(overflow), 64'(0));
        check("pl_cnt", 64'(vec_count), 64'(5));
        for (int i = 1; i < 5; i++) begin
            for (int j = 0; j < 8; j++) begin
                check("pl_drain_valid", 64'(elem_valid), 64'(1));
                check("pl_drain_data", 64'(elem_data), 64'(elem_of(i, j)));
                step();
            end
        end
        check("pl_end_valid", 64'(elem_valid), 64'(0));
        check("pl_end_busy", 64'(busy), 64'(0));

        // ---------------- Reset mid-drain ----------------
        do_reset();
        elem_ready = 1'b0;
        outFlag    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out = make_vec(i);
            step();
        end
        outFlag    = 1'b0;
        elem_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("mr_pre_data", 64'(elem_data), 64'(elem_of(0, j)));
            step();
        end
        reset = 1'b1;
        step();
        check("mr_valid", 64'(elem_valid), 64'(0));
        check("mr_busy", 64'(busy), 64'(0));
        check("mr_cnt", 64'(vec_count), 64'(0));
        check("mr_data", 64'(elem_data), 64'(0));
        check("mr_last", 64'(elem_last), 64'(0));
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("mr_after_valid", 64'(elem_valid), 64'(0));
            check("mr_after_busy", 64'(busy), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vector_output_drain.md
Name: vector_output_drain

Overview:
- Consumer-side endpoint for the CPU result port: samples the packed output vector whenever the output-valid flag is high, and buffers it in a small vector FIFO.
- Drains each buffered vector as a stream of OUTPUT_WIDTH-bit elements over a valid/ready byte interface.
- Sits between the CPU top and a host link (UART or debug bridge) so that CPU output bursts are never lost to downstream stalls, up to the FIFO depth.

Parameters:
- VECTOR_SIZE, 8, elements per output vector
- OUTPUT_WIDTH, 8, bits per element
- FIFO_DEPTH, 4, vectors buffered; power of two, minimum 2
- COUNT_WIDTH, 16, width of the accepted-vector counter

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- out  in  VECTOR_SIZE*OUTPUT_WIDTH  packed CPU output vector; element i is out[i*OUTPUT_WIDTH +: OUTPUT_WIDTH]
- outFlag  in  1  out is valid this cycle; one vector per high cycle
- elem_data  out  OUTPUT_WIDTH  current element
- elem_valid  out  1  elem_data is valid
- elem_ready  in  1  downstream accepts the element
- elem_last  out  1  high with element VECTOR_SIZE-1 of a vector
- overflow  out  1  sticky: a vector was dropped
- vec_count  out  COUNT_WIDTH  vectors accepted into the FIFO; wraps modulo 2^COUNT_WIDTH
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset, sampled at a rising edge, forces every register to its reset value on that edge:
  - FIFO pointers and occupancy cleared.
  - FSM to IDLE.
  - elem_valid=0, elem_last=0, elem_data=0, overflow=0, vec_count=0, busy=0.
  - Reset mid-drain discards the partial vector and all buffered vectors; no further elements are emitted.
- Capture:
  - At each edge with outFlag=1 and the FIFO not full, out is written at the tail and vec_count increments by 1.
  - With outFlag=1 and the FIFO full, the vector is dropped, overflow is set to 1, and vec_count is unchanged.
  - Full is judged after the same-edge pop: if a pop occurs on that edge, the push is accepted.
- FSM states: IDLE, SEND.
  - IDLE: if occupancy != 0, the head vector is loaded into the shift register, element index is set to 0, and the FSM moves to SEND. elem_valid=1 from the next cycle.
  - SEND: elem_data equals shift-register element [index]; elem_valid=1; elem_last=(index==VECTOR_SIZE-1).
  - A transfer occurs on an edge with elem_valid && elem_ready.
  - Transfer with index<VECTOR_SIZE-1: index increments and elem_data advances on the same edge.
  - Transfer with index==VECTOR_SIZE-1: the head is popped on that edge. If the FIFO still holds another vector after the pop, the next vector loads directly and SEND continues with no bubble (elem_valid stays 1). Otherwise the FSM returns to IDLE and elem_valid=0.
  - elem_ready=0 in SEND: elem_data, elem_valid and elem_last hold stable.
- Latency: outFlag high at edge k into an empty, idle block gives the first element valid after edge k+1. Best case, a vector then drains in VECTOR_SIZE cycles.
- Element order: element 0 (least-significant slice) first.
- elem_valid never depends combinationally on elem_ready.
- Pointers wrap modulo FIFO_DEPTH. Occupancy ranges 0..FIFO_DEPTH.
- overflow clears only on reset.
- Bit widths are preserved exactly; no arithmetic is performed on data.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 1 edge, then outFlag=0 for 10 cycles.
  - Required: elem_valid=0, busy=0, vec_count=0, overflow=0 throughout.
- Single vector, elem_ready=1:
  - Stimulus: out=64'h0807060504030201 with outFlag=1 for 1 edge (edge k).
  - Required: elements 01,02,…,08 on 8 consecutive cycles starting after edge k+1; elem_last=1 only with 08; vec_count=1; busy falls after the last transfer.
- Backpressure:
  - Stimulus: same vector; elem_ready toggles 1,0,0,1,…
  - Required: elem_data holds while elem_ready=0; the output sequence is still 01..08 with no duplicates or skips.
- Overflow:
  - Stimulus: elem_ready=0; 5 consecutive outFlag pulses with vectors A0..A4, FIFO_DEPTH=4.
  - Required: vec_count=4, overflow=1, A4 dropped.
  - Then with elem_ready=1: A0..A3 drain back-to-back as 32 elements with no idle cycles.
- Push while draining last element:
  - Setup: FIFO full, SEND, index=7.
  - Stimulus: outFlag=1 on the same edge that elem_ready=1 completes the transfer.
  - Required: the push is accepted, overflow stays 0, and vec_count increments.
- Reset mid-drain:
  - Stimulus: assert reset after element 3 of a vector, with 2 vectors queued.
  - Required: elem_valid=0, busy=0, vec_count=0 after that edge; no further elements after reset deasserts.
